// File: rtl/rob_pkg.sv
// ROB shared configuration: widths, reserved-tag constants, entry layout and
// the circular-pointer helper. Imported by rob and rob_lookup.
package rob_pkg;

    localparam int ROBSize      = 16;
    localparam int ROBIdxWidth  = 4;
    localparam int WordWidth    = 32;
    localparam int RegIdxWidth  = 5;
    localparam int InstrIdWidth = 6;

    localparam logic [WordWidth-1:0]    ZERO      = '0;
    localparam logic [InstrIdWidth-1:0] INSTR_NOP = '0;

    // Per-slot payload; the ready bits live in a separate vector so a flush
    // can clear them all in one cycle.
    typedef struct packed {
        logic [InstrIdWidth-1:0] instr_id;
        logic [RegIdxWidth-1:0]  rd;
        logic [WordWidth-1:0]    res;
        logic                    mispredict;
    } rob_entry_t;

    // Tag 0 means "no tag", so pointers cycle 1..size-1 and skip 0.
    function automatic logic [ROBIdxWidth-1:0] rob_next(input logic [ROBIdxWidth-1:0] pos,
                                                        input int size);
        return (int'(pos) == size - 1) ? ROBIdxWidth'(1) : ROBIdxWidth'(pos + 1'b1);
    endfunction

endpackage

// File: rtl/rob_lookup.sv
// Operand-tag lookup into the ROB.
// Ports: tag (query), ready_vec/res_vec (ROB state), cdb_en/cdb_pos/cdb_res
// (same-cycle writeback), ready/val (result).
// Tag 0 is "no dependency": always ready with value 0.
// Option: define ROB_BYPASS_EN to forward a same-cycle CDB result
// combinationally; otherwise it becomes visible the cycle after the write.
module rob_lookup
    import rob_pkg::*;
#(
    parameter int ROB_SIZE = ROBSize
) (
    input  logic [ROBIdxWidth-1:0]             tag,
    input  logic [ROB_SIZE-1:0]                ready_vec,
    input  logic [ROB_SIZE-1:0][WordWidth-1:0] res_vec,
    input  logic                               cdb_en,
    input  logic [ROBIdxWidth-1:0]             cdb_pos,
    input  logic [WordWidth-1:0]               cdb_res,
    output logic                               ready,
    output logic [WordWidth-1:0]               val
);

`ifndef ROB_BYPASS_EN
    logic unused_cdb;
    assign unused_cdb = &{1'b0, cdb_en, cdb_pos, cdb_res};
`endif

    always_comb begin
        ready = 1'b1;
        val   = ZERO;
        if (tag != '0) begin
            ready = 1'b0;
`ifdef ROB_BYPASS_EN
            if (cdb_en && cdb_pos == tag) begin
                ready = 1'b1;
                val   = cdb_res;
            end else
`endif
            if (int'(tag) < ROB_SIZE) begin
                ready = ready_vec[tag];
                val   = res_vec[tag];
            end
        end
    end

endmodule

// File: rtl/rob.sv
// Reorder buffer: circular queue of in-flight instructions, in-order commit
// to the register file, flush on a mispredicted commit.
// Ports: clk_in/rst_in (sync, active-high)/rdy_in (global enable);
//   issue_*   allocate at tail, issue_rob_pos_out is the tag handed out;
//   full_out  no free slot;
//   cdb_*     execution-result writeback;
//   rs1/rs2   operand tag lookup (two rob_lookup instances);
//   commit_to_regfile_* one-cycle registered commit pulse and payload;
//   clear_branch_out    one-cycle flush pulse.
// Option: ROB_BYPASS_EN enables CDB->lookup forwarding in rob_lookup.
module rob
    import rob_pkg::*;
#(
    parameter int ROB_SIZE = ROBSize
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    issue_en_in,
    input  logic [InstrIdWidth-1:0] issue_instr_id_in,
    input  logic [RegIdxWidth-1:0]  issue_rd_in,
    output logic [ROBIdxWidth-1:0]  issue_rob_pos_out,
    output logic                    full_out,
    input  logic                    cdb_en_in,
    input  logic [ROBIdxWidth-1:0]  cdb_rob_pos_in,
    input  logic [WordWidth-1:0]    cdb_res_in,
    input  logic                    cdb_mispredict_in,
    input  logic [ROBIdxWidth-1:0]  rs1_tag_in,
    input  logic [ROBIdxWidth-1:0]  rs2_tag_in,
    output logic                    rs1_ready_out,
    output logic                    rs2_ready_out,
    output logic [WordWidth-1:0]    rs1_val_out,
    output logic [WordWidth-1:0]    rs2_val_out,
    output logic                    commit_to_regfile_en_out,
    output logic [InstrIdWidth-1:0] commit_to_regfile_instr_id_out,
    output logic [RegIdxWidth-1:0]  commit_to_regfile_rd_out,
    output logic [ROBIdxWidth-1:0]  commit_to_regfile_rob_pos_out,
    output logic [WordWidth-1:0]    commit_to_regfile_res_out,
    output logic                    clear_branch_out
);

    logic [ROBIdxWidth-1:0]             head, tail, count;
    logic [ROB_SIZE-1:0]                ready_q;
    rob_entry_t [ROB_SIZE-1:0]          ent;
    logic [ROB_SIZE-1:0][WordWidth-1:0] res_vec;
    logic                               do_commit, do_flush, do_issue, do_cdb;

    assign issue_rob_pos_out = tail;
    assign full_out          = (int'(count) == ROB_SIZE - 1);

    // A flush wins over everything else happening in the same cycle: the
    // younger issue and any CDB write belong to the squashed path.
    always_comb begin
        do_commit = rdy_in && (count != '0) && ready_q[head];
        do_flush  = do_commit && ent[head].mispredict;
        do_issue  = rdy_in && issue_en_in && !full_out && !do_flush;
        do_cdb    = rdy_in && cdb_en_in && (cdb_rob_pos_in != '0)
                    && (int'(cdb_rob_pos_in) < ROB_SIZE) && !do_flush;
    end

    always_comb begin
        for (int i = 0; i < ROB_SIZE; i++) res_vec[i] = ent[i].res;
    end

    // Control state and registered commit outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head                           <= ROBIdxWidth'(1);
            tail                           <= ROBIdxWidth'(1);
            count                          <= '0;
            ready_q                        <= '0;
            commit_to_regfile_en_out       <= 1'b0;
            commit_to_regfile_instr_id_out <= INSTR_NOP;
            commit_to_regfile_rd_out       <= '0;
            commit_to_regfile_rob_pos_out  <= '0;
            commit_to_regfile_res_out      <= ZERO;
            clear_branch_out               <= 1'b0;
        end else begin
            commit_to_regfile_en_out <= do_commit;
            clear_branch_out         <= do_flush;
            if (do_commit) begin
                commit_to_regfile_instr_id_out <= ent[head].instr_id;
                commit_to_regfile_rd_out       <= ent[head].rd;
                commit_to_regfile_rob_pos_out  <= head;
                commit_to_regfile_res_out      <= ent[head].res;
            end
            if (do_flush) begin
                head    <= ROBIdxWidth'(1);
                tail    <= ROBIdxWidth'(1);
                count   <= '0;
                ready_q <= '0;
            end else begin
                if (do_commit) begin
                    head          <= rob_next(head, ROB_SIZE);
                    ready_q[head] <= 1'b0;
                end
                if (do_cdb) ready_q[cdb_rob_pos_in] <= 1'b1;
                // Issue last so a freshly allocated slot always starts not-ready.
                if (do_issue) begin
                    tail          <= rob_next(tail, ROB_SIZE);
                    ready_q[tail] <= 1'b0;
                end
                case ({do_issue, do_commit})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry payload; qualified by ready_q/count, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            if (do_issue) begin
                ent[tail].instr_id   <= issue_instr_id_in;
                ent[tail].rd         <= issue_rd_in;
                ent[tail].mispredict <= 1'b0;
            end
            if (do_cdb) begin
                ent[cdb_rob_pos_in].res        <= cdb_res_in;
                ent[cdb_rob_pos_in].mispredict <= cdb_mispredict_in;
            end
        end
    end

    // Operand lookups: port 0 = rs1, port 1 = rs2.
    logic [1:0][ROBIdxWidth-1:0] q_tag;
    logic [1:0]                  q_ready;
    logic [1:0][WordWidth-1:0]   q_val;

    assign q_tag = {rs2_tag_in, rs1_tag_in};

    for (genvar g = 0; g < 2; g++) begin : g_lookup
        rob_lookup #(.ROB_SIZE(ROB_SIZE)) u_lookup (
            .tag       (q_tag[g]),
            .ready_vec (ready_q),
            .res_vec   (res_vec),
            .cdb_en    (cdb_en_in),
            .cdb_pos   (cdb_rob_pos_in),
            .cdb_res   (cdb_res_in),
            .ready     (q_ready[g]),
            .val       (q_val[g])
        );
    end

    assign rs1_ready_out = q_ready[0];
    assign rs2_ready_out = q_ready[1];
    assign rs1_val_out   = q_val[0];
    assign rs2_val_out   = q_val[1];

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: commit scoreboard plus per-scenario checks.
module tb_rob;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        issue_en_in = 1'b0;
    logic [5:0]  issue_instr_id_in = '0;
    logic [4:0]  issue_rd_in = '0;
    logic [3:0]  issue_rob_pos_out;
    logic        full_out;
    logic        cdb_en_in = 1'b0;
    logic [3:0]  cdb_rob_pos_in = '0;
    logic [31:0] cdb_res_in = '0;
    logic        cdb_mispredict_in = 1'b0;
    logic [3:0]  rs1_tag_in = '0, rs2_tag_in = '0;
    logic        rs1_ready_out, rs2_ready_out;
    logic [31:0] rs1_val_out, rs2_val_out;
    logic        commit_to_regfile_en_out;
    logic [5:0]  commit_to_regfile_instr_id_out;
    logic [4:0]  commit_to_regfile_rd_out;
    logic [3:0]  commit_to_regfile_rob_pos_out;
    logic [31:0] commit_to_regfile_res_out;
    logic        clear_branch_out;

    rob dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_en_in(issue_en_in), .issue_instr_id_in(issue_instr_id_in),
        .issue_rd_in(issue_rd_in), .issue_rob_pos_out(issue_rob_pos_out),
        .full_out(full_out), .cdb_en_in(cdb_en_in), .cdb_rob_pos_in(cdb_rob_pos_in),
        .cdb_res_in(cdb_res_in), .cdb_mispredict_in(cdb_mispredict_in),
        .rs1_tag_in(rs1_tag_in), .rs2_tag_in(rs2_tag_in),
        .rs1_ready_out(rs1_ready_out), .rs2_ready_out(rs2_ready_out),
        .rs1_val_out(rs1_val_out), .rs2_val_out(rs2_val_out),
        .commit_to_regfile_en_out(commit_to_regfile_en_out),
        .commit_to_regfile_instr_id_out(commit_to_regfile_instr_id_out),
        .commit_to_regfile_rd_out(commit_to_regfile_rd_out),
        .commit_to_regfile_rob_pos_out(commit_to_regfile_rob_pos_out),
        .commit_to_regfile_res_out(commit_to_regfile_res_out),
        .clear_branch_out(clear_branch_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [3:0] pos;
        logic [5:0] id;
        logic [4:0] rd;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mres[16];
    logic        mmp[16];
    logic [3:0]  mtail = 4'd1;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [3:0] nxt(input logic [3:0] p);
        return (p == 4'd15) ? 4'd1 : p + 4'd1;
    endfunction

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset;
        rst_in = 1'b1;
        tick;
        tick;
        rst_in = 1'b0;
        sb.delete();
        mtail = 4'd1;
    endtask

    task automatic issue(input logic [5:0] id, input logic [4:0] rd);
        exp_t e;
        e.pos = mtail; e.id = id; e.rd = rd;
        sb.push_back(e);
        issue_en_in = 1'b1; issue_instr_id_in = id; issue_rd_in = rd;
        tick;
        issue_en_in = 1'b0;
        mtail = nxt(mtail);
    endtask

    task automatic cdb(input logic [3:0] pos, input logic [31:0] res, input logic mp);
        mres[pos] = res; mmp[pos] = mp;
        cdb_en_in = 1'b1; cdb_rob_pos_in = pos; cdb_res_in = res; cdb_mispredict_in = mp;
        tick;
        cdb_en_in = 1'b0; cdb_mispredict_in = 1'b0;
    endtask

    // Commit scoreboard: every commit pulse must match the oldest issued entry.
    always @(negedge clk_in) begin
        exp_t e;
        if (!rst_in && commit_to_regfile_en_out === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL commit_unexpected got pos=%0d want no commit",
                         commit_to_regfile_rob_pos_out);
            end else begin
                e = sb.pop_front();
                if (commit_to_regfile_rob_pos_out !== e.pos || commit_to_regfile_instr_id_out !== e.id ||
                    commit_to_regfile_rd_out !== e.rd || commit_to_regfile_res_out !== mres[e.pos] ||
                    clear_branch_out !== mmp[e.pos]) begin
                    errors++;
                    $display("FAIL commit_sb got pos=%0d id=%0d rd=%0d res=%h clr=%b want pos=%0d id=%0d rd=%0d res=%h clr=%b",
                             commit_to_regfile_rob_pos_out, commit_to_regfile_instr_id_out,
                             commit_to_regfile_rd_out, commit_to_regfile_res_out, clear_branch_out,
                             e.pos, e.id, e.rd, mres[e.pos], mmp[e.pos]);
                end
                if (mmp[e.pos]) sb.delete();
            end
        end
    end

    task automatic test_reset;
        rdy_in = 1'b1;
        do_reset;
        rs1_tag_in = 4'd0; rs2_tag_in = 4'd3;
        #1;
        checks += 5;
        if (commit_to_regfile_en_out !== 1'b0 || clear_branch_out !== 1'b0) begin
            errors++; $display("FAIL reset_pulses got en=%b clr=%b want 0 0", commit_to_regfile_en_out, clear_branch_out);
        end
        if (issue_rob_pos_out !== 4'd1) begin errors++; $display("FAIL reset_pos got %0d want 1", issue_rob_pos_out); end
        if (full_out !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full_out); end
        if (rs1_ready_out !== 1'b1 || rs1_val_out !== 32'd0) begin
            errors++; $display("FAIL tag0_lookup got rdy=%b val=%h want 1 0", rs1_ready_out, rs1_val_out);
        end
        if (rs2_ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", rs2_ready_out); end
        // Reset mid-operation with a commit pending and rdy low.
        issue(6'd1, 5'd1);
        issue(6'd2, 5'd2);
        cdb(4'd1, 32'h11, 1'b0);
        rst_in = 1'b1; rdy_in = 1'b0; issue_en_in = 1'b1;
        cdb_en_in = 1'b1; cdb_rob_pos_in = 4'd2; cdb_res_in = 32'h22;
        tick;
        rst_in = 1'b0; rdy_in = 1'b1; issue_en_in = 1'b0; cdb_en_in = 1'b0;
        sb.delete(); mtail = 4'd1;
        checks += 2;
        if (commit_to_regfile_en_out !== 1'b0) begin errors++; $display("FAIL midrst_en got %b want 0", commit_to_regfile_en_out); end
        if (issue_rob_pos_out !== 4'd1 || full_out !== 1'b0) begin
            errors++; $display("FAIL midrst_pos got pos=%0d full=%b want 1 0", issue_rob_pos_out, full_out);
        end
        rs1_tag_in = 4'd1; rs2_tag_in = 4'd2;
        tick;
        checks += 2;
        if (commit_to_regfile_en_out !== 1'b0) begin errors++; $display("FAIL midrst_nocommit got %b want 0", commit_to_regfile_en_out); end
        if (rs1_ready_out !== 1'b0 || rs2_ready_out !== 1'b0) begin
            errors++; $display("FAIL midrst_ready got %b%b want 00", rs1_ready_out, rs2_ready_out);
        end
    endtask

    task automatic test_issue;
        logic [3:0] want;
        for (int i = 0; i < 3; i++) begin
            want = 4'(i + 1);
            checks++;
            if (issue_rob_pos_out !== want) begin errors++; $display("FAIL issue_pos got %0d want %0d", issue_rob_pos_out, want); end
            issue(6'(i + 3), 5'(i + 7));
        end
        checks++;
        if (issue_rob_pos_out !== 4'd4 || full_out !== 1'b0) begin
            errors++; $display("FAIL issue3_state got pos=%0d full=%b want 4 0", issue_rob_pos_out, full_out);
        end
    endtask

    task automatic test_commit_latency;
        rs1_tag_in = 4'd1;
        cdb(4'd1, 32'h55, 1'b0);
        checks += 2;
        if (commit_to_regfile_en_out !== 1'b0) begin errors++; $display("FAIL lat_early got %b want 0", commit_to_regfile_en_out); end
        if (rs1_ready_out !== 1'b1 || rs1_val_out !== 32'h55) begin
            errors++; $display("FAIL lat_lookup got rdy=%b val=%h want 1 55", rs1_ready_out, rs1_val_out);
        end
        tick;
        checks++;
        if (commit_to_regfile_en_out !== 1'b1 || commit_to_regfile_rob_pos_out !== 4'd1 ||
            commit_to_regfile_res_out !== 32'h55) begin
            errors++; $display("FAIL lat_commit got en=%b pos=%0d res=%h want 1 1 55",
                               commit_to_regfile_en_out, commit_to_regfile_rob_pos_out, commit_to_regfile_res_out);
        end
        tick;
        checks++;
        if (commit_to_regfile_en_out !== 1'b0) begin errors++; $display("FAIL lat_pulse got %b want 0", commit_to_regfile_en_out); end
    endtask

    task automatic test_commit_order;
        do_reset;
        issue(6'd10, 5'd10);
        issue(6'd11, 5'd11);
        cdb(4'd2, 32'h22, 1'b0);
        checks++;
        if (commit_to_regfile_en_out !== 1'b0) begin errors++; $display("FAIL order_hold got %b want 0", commit_to_regfile_en_out); end
        cdb(4'd1, 32'h11, 1'b0);
        checks++;
        if (commit_to_regfile_en_out !== 1'b0) begin errors++; $display("FAIL order_early got %b want 0", commit_to_regfile_en_out); end
        issue(6'd12, 5'd12);  // lands on the same edge as commit of pos 1
        checks += 2;
        if (commit_to_regfile_en_out !== 1'b1 || commit_to_regfile_rob_pos_out !== 4'd1) begin
            errors++; $display("FAIL order_first got en=%b pos=%0d want 1 1", commit_to_regfile_en_out, commit_to_regfile_rob_pos_out);
        end
        if (issue_rob_pos_out !== 4'd4) begin errors++; $display("FAIL order_tail got %0d want 4", issue_rob_pos_out); end
        tick;
        checks++;
        if (commit_to_regfile_en_out !== 1'b1 || commit_to_regfile_rob_pos_out !== 4'd2) begin
            errors++; $display("FAIL order_second got en=%b pos=%0d want 1 2", commit_to_regfile_en_out, commit_to_regfile_rob_pos_out);
        end
        tick;
        checks++;
        if (commit_to_regfile_en_out !== 1'b0) begin errors++; $display("FAIL order_third_wait got %b want 0", commit_to_regfile_en_out); end
        cdb(4'd3, 32'h33, 1'b0);
        tick;
        checks++;
        if (commit_to_regfile_en_out !== 1'b1 || commit_to_regfile_res_out !== 32'h33) begin
            errors++; $display("FAIL order_third got en=%b res=%h want 1 33", commit_to_regfile_en_out, commit_to_regfile_res_out);
        end
    endtask

    task automatic test_rdy_hold;
        issue(6'd13, 5'd13);  // pos 4
        cdb(4'd4, 32'h44, 1'b0);
        rdy_in = 1'b0; issue_en_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick;
            checks++;
            if (commit_to_regfile_en_out !== 1'b0 || issue_rob_pos_out !== 4'd5) begin
                errors++; $display("FAIL rdy_hold got en=%b pos=%0d want 0 5", commit_to_regfile_en_out, issue_rob_pos_out);
            end
        end
        rdy_in = 1'b1; issue_en_in = 1'b0;
        tick;
        checks++;
        if (commit_to_regfile_en_out !== 1'b1 || commit_to_regfile_rob_pos_out !== 4'd4) begin
            errors++; $display("FAIL rdy_resume got en=%b pos=%0d want 1 4", commit_to_regfile_en_out, commit_to_regfile_rob_pos_out);
        end
    endtask

    task automatic test_full_wrap;
        do_reset;
        for (int i = 1; i <= 15; i++) issue(6'(i), 5'(i));
        checks++;
        if (full_out !== 1'b1 || issue_rob_pos_out !== 4'd1) begin
            errors++; $display("FAIL full_set got full=%b pos=%0d want 1 1", full_out, issue_rob_pos_out);
        end
        issue_en_in = 1'b1; issue_instr_id_in = 6'd63;
        tick;
        issue_en_in = 1'b0;
        checks++;
        if (full_out !== 1'b1 || issue_rob_pos_out !== 4'd1) begin
            errors++; $display("FAIL full_ignore got full=%b pos=%0d want 1 1", full_out, issue_rob_pos_out);
        end
        cdb(4'd1, 32'h100, 1'b0);
        issue_en_in = 1'b1;  // still full on this edge: ignored
        tick;
        issue_en_in = 1'b0;
        checks++;
        if (commit_to_regfile_en_out !== 1'b1 || issue_rob_pos_out !== 4'd1 || full_out !== 1'b0) begin
            errors++; $display("FAIL full_commit got en=%b pos=%0d full=%b want 1 1 0",
                               commit_to_regfile_en_out, issue_rob_pos_out, full_out);
        end
        issue(6'd20, 5'd20);  // wraps into slot 1
        checks++;
        if (issue_rob_pos_out !== 4'd2 || full_out !== 1'b1) begin
            errors++; $display("FAIL full_wrap got pos=%0d full=%b want 2 1", issue_rob_pos_out, full_out);
        end
        for (int p = 2; p <= 15; p++) cdb(4'(p), 32'h1000 + 32'(p), 1'b0);
        cdb(4'd1, 32'h2000, 1'b0);
        for (int n = 0; n < 40 && sb.size() != 0; n++) tick;
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL full_drain got left=%0d want 0", sb.size()); end
    endtask

    task automatic test_mispredict;
        do_reset;
        for (int i = 1; i <= 5; i++) issue(6'(i + 30), 5'(i));
        cdb(4'd1, 32'h1, 1'b0);
        cdb(4'd2, 32'h2, 1'b0);
        cdb(4'd3, 32'h3, 1'b0);
        cdb(4'd4, 32'h4444, 1'b1);
        // Flush edge: this issue and CDB write must be dropped.
        issue_en_in = 1'b1; cdb_en_in = 1'b1; cdb_rob_pos_in = 4'd5; cdb_res_in = 32'h5555;
        tick;
        issue_en_in = 1'b0; cdb_en_in = 1'b0;
        checks++;
        if (commit_to_regfile_en_out !== 1'b1 || commit_to_regfile_rob_pos_out !== 4'd4 || clear_branch_out !== 1'b1) begin
            errors++; $display("FAIL mp_flush got en=%b pos=%0d clr=%b want 1 4 1",
                               commit_to_regfile_en_out, commit_to_regfile_rob_pos_out, clear_branch_out);
        end
        rs1_tag_in = 4'd5; rs2_tag_in = 4'd3;
        tick;
        checks += 3;
        if (clear_branch_out !== 1'b0 || commit_to_regfile_en_out !== 1'b0) begin
            errors++; $display("FAIL mp_pulse got clr=%b en=%b want 0 0", clear_branch_out, commit_to_regfile_en_out);
        end
        if (issue_rob_pos_out !== 4'd1 || full_out !== 1'b0) begin
            errors++; $display("FAIL mp_state got pos=%0d full=%b want 1 0", issue_rob_pos_out, full_out);
        end
        if (rs1_ready_out !== 1'b0 || rs2_ready_out !== 1'b0) begin
            errors++; $display("FAIL mp_ready got %b%b want 00", rs1_ready_out, rs2_ready_out);
        end
        mtail = 4'd1;
    endtask

    task automatic test_bypass;
        do_reset;
        for (int i = 1; i <= 5; i++) issue(6'(i + 40), 5'(i + 20));
        rs1_tag_in = 4'd5;
        mres[5] = 32'hAB; mmp[5] = 1'b0;
        cdb_en_in = 1'b1; cdb_rob_pos_in = 4'd5; cdb_res_in = 32'hAB; cdb_mispredict_in = 1'b0;
        #1;
        checks++;
`ifdef ROB_BYPASS_EN
        if (rs1_ready_out !== 1'b1 || rs1_val_out !== 32'hAB) begin
            errors++; $display("FAIL bypass_same got rdy=%b val=%h want 1 ab", rs1_ready_out, rs1_val_out);
        end
`else
        if (rs1_ready_out !== 1'b0) begin errors++; $display("FAIL bypass_same got rdy=%b want 0", rs1_ready_out); end
`endif
        tick;
        cdb_en_in = 1'b0;
        checks++;
        if (rs1_ready_out !== 1'b1 || rs1_val_out !== 32'hAB) begin
            errors++; $display("FAIL bypass_next got rdy=%b val=%h want 1 ab", rs1_ready_out, rs1_val_out);
        end
        for (int p = 1; p <= 4; p++) cdb(4'(p), 32'hC0 + 32'(p), 1'b0);
        for (int n = 0; n < 20 && sb.size() != 0; n++) tick;
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL bypass_drain got left=%0d want 0", sb.size()); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin mres[i] = '0; mmp[i] = 1'b0; end
        test_reset;
        test_issue;
        test_commit_latency;
        test_commit_order;
        test_rdy_hold;
        test_full_wrap;
        test_mispredict;
        test_bypass;
        tick;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
